// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks: default operand
// width and the common IDLE/CALC/DONE state encoding.
package seq_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage : seq_arith_pkg

// File: rtl/mul_add_step.sv
// One shift-add step of the sequential multiply-add: adds rop << bit_idx to
// the accumulator when the current multiplier bit is set.
module mul_add_step #(
  parameter int WIDTH = 8,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   rop,
  input  logic [CW-1:0]      bit_idx,
  input  logic               quot_bit,
  output logic [2*WIDTH-1:0] next_acc
);

  logic [2*WIDTH-1:0] shifted;

  assign shifted  = {{WIDTH{1'b0}}, rop} << bit_idx;
  assign next_acc = quot_bit ? (acc + shifted) : acc;

endmodule : mul_add_step

// File: rtl/seq_mul_add8.sv
// Sequential multiply-add: lop = quot*rop + mod, one multiplier bit per cycle,
// with ready/valid handshakes on both sides and no overlap between operations.
module seq_mul_add8
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rop,
  input  logic [WIDTH-1:0]   mod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] lop,
  output logic               ovf,
  output logic               rem_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t         state, next_state;
  logic [WIDTH-1:0]   quot_r, rop_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, next_acc;
  logic               rem_err_pend;
  logic               accept, last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));

  mul_add_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc      (acc),
    .rop      (rop_r),
    .bit_idx  (cnt),
    .quot_bit (quot_r[cnt]),
    .next_acc (next_acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result registers only change on the final CALC step, so they hold across
  // the handshake until the next result lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_r       <= '0;
      rop_r        <= '0;
      cnt          <= '0;
      acc          <= '0;
      rem_err_pend <= 1'b0;
      lop          <= '0;
      ovf          <= 1'b0;
      rem_err      <= 1'b0;
    end else if (accept) begin
      quot_r       <= quot;
      rop_r        <= rop;
      cnt          <= '0;
      acc          <= {{WIDTH{1'b0}}, mod};
      rem_err_pend <= (mod >= rop);
    end else if (state == CALC) begin
      acc <= next_acc;
      cnt <= cnt + CW'(1);
      if (last_step) begin
        lop     <= next_acc;
        ovf     <= |next_acc[2*WIDTH-1:WIDTH];
        rem_err <= rem_err_pend;
      end
    end
  end

endmodule : seq_mul_add8

// File: tb/tb_seq_mul_add8.sv
// Directed and randomized self-checking bench for seq_mul_add8.
module tb_seq_mul_add8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  quot, rop, mod;
  logic        out_valid, out_ready;
  logic [15:0] lop;
  logic        ovf, rem_err;

  int checks = 0;
  int errors = 0;

  seq_mul_add8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quot      (quot),
    .rop       (rop),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lop       (lop),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; operands are accepted on the next rising edge,
  // then scrambled so later input changes must not matter.
  task automatic apply_stimulus(input logic [7:0] q, input logic [7:0] r, input logic [7:0] m);
    in_valid = 1'b1;
    quot = q;
    rop  = r;
    mod  = m;
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    quot = 8'($urandom);
    rop  = 8'($urandom);
    mod  = 8'($urandom);
  endtask

  task automatic wait_result();
    int n = 0;
    while (n <= 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check("latency", n, 8);
  endtask

  task automatic check_output(input string tag, input logic [15:0] exp_lop,
                              input logic exp_ovf, input logic exp_rem, input int stall);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_lop"}, lop, exp_lop);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_rem_err"}, rem_err, exp_rem);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, out_valid, 1'b1);
      check({tag, "_stall_lop"}, lop, exp_lop);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_in_ready"}, in_ready, 1'b1);
    check({tag, "_post_lop_held"}, lop, exp_lop);
  endtask

  initial begin
    logic [7:0]  q, r, m;
    logic [15:0] exp_lop;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quot = '0;
    rop  = '0;
    mod  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_lop", lop, 16'h0000);
    check("reset_ovf", ovf, 1'b0);
    check("reset_rem_err", rem_err, 1'b0);
    reset_n = 1'b1;

    // 9*27+12 = 255
    apply_stimulus(8'h09, 8'h1B, 8'h0C);
    check("calc_in_ready", in_ready, 1'b0);
    wait_result();
    check_output("v1", 16'h00FF, 1'b0, 1'b0, 0);

    // 255*255+254 = 0xFEFF, the largest result
    apply_stimulus(8'hFF, 8'hFF, 8'hFE);
    wait_result();
    check_output("v2", 16'hFEFF, 1'b1, 1'b0, 0);

    // 18*14+5 = 257
    apply_stimulus(8'h12, 8'h0E, 8'h05);
    wait_result();
    check_output("v3", 16'h0101, 1'b1, 1'b0, 0);

    apply_stimulus(8'h05, 8'h00, 8'h00);
    wait_result();
    check_output("v4_rop0", 16'h0000, 1'b0, 1'b1, 0);

    apply_stimulus(8'h00, 8'h10, 8'h05);
    wait_result();
    check_output("v5_quot0", 16'h0005, 1'b0, 1'b0, 0);

    // 3*7+2 = 23, then stall in DONE with live, changing inputs
    apply_stimulus(8'h03, 8'h07, 8'h02);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      quot = 8'(i * 37 + 1);
      rop  = 8'(i * 11 + 3);
      mod  = 8'(i * 5);
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_lop", lop, 16'h0017);
      check("stall_ovf", ovf, 1'b0);
      check("stall_rem_err", rem_err, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("stall_release_in_ready", in_ready, 1'b1);
    check("stall_release_out_valid", out_valid, 1'b0);

    // Reset during CALC cycle 3 aborts the operation
    apply_stimulus(8'hAA, 8'h55, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_lop", lop, 16'h0000);
    check("midreset_ovf", ovf, 1'b0);
    check("midreset_rem_err", rem_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("midreset_hold_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    apply_stimulus(8'h03, 8'h04, 8'h01);
    wait_result();
    check_output("post_reset", 16'h000D, 1'b0, 1'b0, 0);

    // Random operand sets with random stalls against the golden model
    for (int k = 0; k < 300; k++) begin
      q = 8'($urandom);
      r = 8'($urandom);
      m = 8'($urandom);
      if (k % 4 == 0) m = (r == 0) ? 8'h00 : 8'(m % r);
      exp_lop = 16'(q) * 16'(r) + 16'(m);
      apply_stimulus(q, r, m);
      wait_result();
      if (lop < 16'd256 && !rem_err) begin
        check("rt_quot", 8'(lop / 16'(r)), q);
        check("rt_mod", 8'(lop % 16'(r)), m);
      end
      check_output("rand", exp_lop, |exp_lop[15:8], m >= r, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_mul_add8
